// File: rtl/fb_write_arbiter.sv
// Single write port arbiter for the 256x256 1-bit plot framebuffer: clear sweep, plot FIFO, overlay.
// Optional saturating drop counter enabled by defining FBARB_DROP_COUNT_EN.
module fb_write_arbiter #(
  parameter int   FIFO_DEPTH  = 4,
  parameter logic CLEAR_VALUE = 1'b0
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic        clear_done,
  input  logic        pl_wr_en,
  input  logic [7:0]  pl_wr_x,
  input  logic [7:0]  pl_wr_y,
  input  logic        pl_wr_data,
  input  logic        ov_vld,
  output logic        ov_rdy,
  input  logic [7:0]  ov_x,
  input  logic [7:0]  ov_y,
  input  logic        ov_data,
  output logic        fb_we,
  output logic [15:0] fb_addr,
  output logic        fb_din,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0] r_clr_addr;
  logic [16:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0] r_cnt;
  logic r_last;

  logic w_idle;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_ov_go;
  logic w_clr_end;
  logic [16:0] w_head;

  assign w_idle    = (r_state == S_IDLE);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_push    = pl_wr_en && w_idle && !clear_req && !w_full;
  assign w_pop     = w_idle && !clear_req && !w_empty;
  assign ov_rdy    = w_idle && w_empty && !clear_req && !rst_sys;
  assign w_ov_go   = ov_vld && ov_rdy;
  assign w_clr_end = !w_idle && !clear_req && (r_clr_addr == 16'hFFFF);
  assign w_head    = r_mem[r_rp];

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (clear_req) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_clr_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A request during a sweep restarts it from address 0.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys)      r_clr_addr <= '0;
    else if (clear_req) r_clr_addr <= '0;
    else if (!w_idle) r_clr_addr <= r_clr_addr + 16'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wp] <= {pl_wr_y, pl_wr_x, pl_wr_data};
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (clear_req) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_din     <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      clear_busy <= !w_idle;
      r_last     <= w_clr_end;
      clear_done <= r_last;
      if (!w_idle) begin
        fb_we   <= 1'b1;
        fb_addr <= r_clr_addr;
        fb_din  <= CLEAR_VALUE;
      end else if (w_pop) begin
        fb_we   <= 1'b1;
        fb_addr <= w_head[16:1];
        fb_din  <= w_head[0];
      end else if (w_ov_go) begin
        fb_we   <= 1'b1;
        fb_addr <= {ov_y, ov_x};
        fb_din  <= ov_data;
      end else begin
        fb_we   <= 1'b0;
      end
    end
  end

`ifdef FBARB_DROP_COUNT_EN
  logic w_drop;
  logic [15:0] r_drop_cnt;

  assign w_drop = pl_wr_en && !w_push;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter.
// Covers reset, plot path, burst, contention, clear sweep with restart, reset mid-clear.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_sys;
  logic        clear_req;
  logic        clear_busy;
  logic        clear_done;
  logic        pl_wr_en;
  logic [7:0]  pl_wr_x;
  logic [7:0]  pl_wr_y;
  logic        pl_wr_data;
  logic        ov_vld;
  logic        ov_rdy;
  logic [7:0]  ov_x;
  logic [7:0]  ov_y;
  logic        ov_data;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic        fb_din;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FBARB_DROP_COUNT_EN
  localparam logic [15:0] EXP_DROP = 16'd3;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  always #5 clk = ~clk;

  fb_write_arbiter dut (
    .clk_sys    (clk),
    .rst_sys    (rst_sys),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .pl_wr_en   (pl_wr_en),
    .pl_wr_x    (pl_wr_x),
    .pl_wr_y    (pl_wr_y),
    .pl_wr_data (pl_wr_data),
    .ov_vld     (ov_vld),
    .ov_rdy     (ov_rdy),
    .ov_x       (ov_x),
    .ov_y       (ov_y),
    .ov_data    (ov_data),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_din     (fb_din),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  logic [16:0] q[$];
  logic [16:0] e;
  int bad;
  int n_done;
  int ea;

  initial begin
    rst_sys    = 1'b1;
    clear_req  = 1'b0;
    pl_wr_en   = 1'b0;
    pl_wr_x    = '0;
    pl_wr_y    = '0;
    pl_wr_data = 1'b0;
    ov_vld     = 1'b0;
    ov_x       = '0;
    ov_y       = '0;
    ov_data    = 1'b0;

    cyc;
    cyc;
    chk("rst_we", fb_we, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_din", fb_din, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_ovrdy", ov_rdy, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_sys = 1'b0;
    cyc;
    chk("idle_ovrdy", ov_rdy, 1);

    // single plot point
    pl_wr_en = 1'b1; pl_wr_x = 8'h12; pl_wr_y = 8'h34; pl_wr_data = 1'b1;
    cyc;
    pl_wr_en = 1'b0;
    chk("pt_we_k", fb_we, 0);
    cyc;
    chk("pt_we", fb_we, 1);
    chk("pt_addr", fb_addr, 16'h3412);
    chk("pt_din", fb_din, 1);
    cyc;
    chk("pt_we_off", fb_we, 0);

    // burst of 6 strobes
    q.delete();
    for (int c = 0; c < 9; c++) begin
      if (c < 6) begin
        pl_wr_en = 1'b1;
        pl_wr_x = 8'(c);
        pl_wr_y = 8'(8'h50 + c);
        pl_wr_data = 1'(c & 1);
      end else begin
        pl_wr_en = 1'b0;
      end
      cyc;
      if (fb_we) q.push_back({fb_addr, fb_din});
    end
    chk("burst_n", q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      e = {8'(8'h50 + i), 8'(i), 1'(i & 1)};
      if (i < q.size()) chk("burst_wr", q[i], e);
    end
    chk("burst_drop", drop_cnt, 0);

    // contention: overlay waits for FIFO to drain
    pl_wr_en = 1'b1; pl_wr_x = 8'h01; pl_wr_y = 8'h02; pl_wr_data = 1'b1;
    cyc;
    chk("ctn_rdy1", ov_rdy, 0);
    pl_wr_x = 8'h03; pl_wr_y = 8'h04; pl_wr_data = 1'b0;
    ov_vld = 1'b1; ov_x = 8'hAA; ov_y = 8'hBB; ov_data = 1'b1;
    cyc;
    pl_wr_en = 1'b0;
    chk("ctn_rdy2", ov_rdy, 0);
    chk("ctn_p0_we", fb_we, 1);
    chk("ctn_p0_addr", fb_addr, 16'h0201);
    cyc;
    chk("ctn_rdy3", ov_rdy, 1);
    chk("ctn_p1_addr", fb_addr, 16'h0403);
    chk("ctn_p1_din", fb_din, 0);
    cyc;
    ov_vld = 1'b0;
    chk("ctn_ov_we", fb_we, 1);
    chk("ctn_ov_addr", fb_addr, 16'hBBAA);
    chk("ctn_ov_din", fb_din, 1);
    cyc;
    chk("ctn_we_off", fb_we, 0);

    // clear sweep restarted at 0x1000, with 3 strobes dropped
    bad = 0;
    n_done = 0;
    clear_req = 1'b1;
    cyc;
    clear_req = 1'b0;
    chk("clr_k_we", fb_we, 0);
    chk("clr_k_busy", clear_busy, 0);
    for (int i = 0; i < 'h11001; i++) begin
      clear_req = (i == 'h1000);
      pl_wr_en = (i >= 5 && i <= 7);
      cyc;
      ea = (i <= 'h1000) ? i : i - 'h1001;
      if (!fb_we || !clear_busy || fb_addr !== ea[15:0] || fb_din !== 1'b0)
        bad++;
      if (clear_done) n_done++;
    end
    clear_req = 1'b0;
    pl_wr_en = 1'b0;
    chk("clr_seq_bad", bad, 0);
    chk("clr_early_done", n_done, 0);
    cyc;
    chk("clr_done", clear_done, 1);
    chk("clr_busy_end", clear_busy, 0);
    chk("clr_we_end", fb_we, 0);
    cyc;
    chk("clr_done_pulse", clear_done, 0);
    chk("clr_drop", drop_cnt, EXP_DROP);

    // reset mid-clear
    clear_req = 1'b1;
    cyc;
    clear_req = 1'b0;
    repeat ('h200) cyc;
    chk("mid_addr", fb_addr, 16'h01FF);
    chk("mid_busy", clear_busy, 1);
    rst_sys = 1'b1;
    #1;
    chk("mid_rst_we", fb_we, 0);
    chk("mid_rst_busy", clear_busy, 0);
    cyc;
    rst_sys = 1'b0;
    chk("mid_rst_drop", drop_cnt, 0);
    cyc;
    chk("post_busy", clear_busy, 0);
    chk("post_we", fb_we, 0);
    pl_wr_en = 1'b1; pl_wr_x = 8'h78; pl_wr_y = 8'h9A; pl_wr_data = 1'b1;
    cyc;
    pl_wr_en = 1'b0;
    chk("post_pt_k", fb_we, 0);
    cyc;
    chk("post_pt_we", fb_we, 1);
    chk("post_pt_addr", fb_addr, 16'h9A78);
    chk("post_pt_din", fb_din, 1);
    cyc;
    chk("post_pt_off", fb_we, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
